// File: rtl/spi_reg_responder.sv
// Register-mapped SPI responder: oversamples SCK/CS/PICO on clk and decodes
// command/data frames in all four CPOL/CPHA modes against a local register bank.
module spi_reg_responder #(
    parameter int BUS_LENGTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCK,
    input  logic                  CS,
    input  logic                  PICO,
    input  logic                  CPOL,
    input  logic                  CPHA,
    output logic                  POCI,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    output logic [BUS_LENGTH-1:0] host_rdata,
    input  logic                  host_we,
    input  logic [BUS_LENGTH-1:0] host_wdata,
    output logic                  wr_strobe,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BUS_LENGTH-1:0] wr_data,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(BUS_LENGTH + 1);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sck_sync, cs_sync, pico_sync, cs_vld;
    logic                    sck_prev, cs_prev, armed;
    logic                    sck_s, cs_s, pico_s;
    logic                    lead, trail, sample, shift, cs_fall, cs_rise, last_bit;
    logic [CNT_W-1:0]        bit_cnt, shift_cnt;
    logic [BUS_LENGTH-1:0]   rx, rx_next, tx;
    logic                    rw;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [BUS_LENGTH-1:0]   regs [DEPTH];

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign pico_s = pico_sync[SYNC_STAGES-1];

    // cs_vld marks when the CS chain holds real pin samples again after reset;
    // until CS is then seen high, a low CS is not treated as a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            pico_sync <= '0;
            cs_vld    <= '0;
            sck_prev  <= CPOL;
            cs_prev   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            pico_sync <= {pico_sync[SYNC_STAGES-2:0], PICO};
            cs_vld    <= {cs_vld[SYNC_STAGES-2:0], 1'b1};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
            if (cs_vld[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
        end
    end

    always_comb begin
        lead     = (sck_s != sck_prev) && (sck_s != CPOL);
        trail    = (sck_s != sck_prev) && (sck_s == CPOL);
        sample   = CPHA ? trail : lead;
        shift    = CPHA ? lead : trail;
        cs_fall  = armed && cs_prev && !cs_s;
        cs_rise  = !cs_prev && cs_s;
        last_bit = (bit_cnt == CNT_W'(BUS_LENGTH - 1));
        rx_next  = {rx[BUS_LENGTH-2:0], pico_s};
    end

    assign host_rdata = regs[host_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_cnt  <= '0;
            rx         <= '0;
            tx         <= '0;
            rw         <= 1'b0;
            addr       <= '0;
            POCI       <= 1'b0;
            wr_strobe  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            wr_strobe  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            // Host write first so a same-address SPI write below overrides it.
            if (host_we) regs[host_addr] <= host_wdata;
            if (cs_rise) begin
                state <= IDLE;
                POCI  <= 1'b0;
                if (state == CMD || state == DATA) frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        POCI <= 1'b0;
                        if (cs_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        POCI <= 1'b0;
                        if (sample) begin
                            rx <= rx_next;
                            if (last_bit) begin
                                rw        <= rx_next[BUS_LENGTH-1];
                                addr      <= rx_next[ADDR_WIDTH-1:0];
                                tx        <= rx_next[BUS_LENGTH-1] ? '0 : regs[rx_next[ADDR_WIDTH-1:0]];
                                bit_cnt   <= '0;
                                shift_cnt <= '0;
                                state     <= DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (sample) begin
                            rx <= rx_next;
                            if (last_bit) begin
                                if (rw) begin
                                    regs[addr] <= rx_next;
                                    wr_strobe  <= 1'b1;
                                    wr_addr    <= addr;
                                    wr_data    <= rx_next;
                                end
                                frame_done <= 1'b1;
                                POCI       <= 1'b0;
                                state      <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (shift) begin
                            if (shift_cnt < CNT_W'(BUS_LENGTH)) begin
                                POCI      <= tx[BUS_LENGTH-1];
                                tx        <= tx << 1;
                                shift_cnt <= shift_cnt + 1'b1;
                            end else begin
                                POCI <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: drives SPI frames in all modes and
// checks register writes, read-back data, aborts, collisions and reset.
module tb_spi_reg_responder;

    localparam int BL   = 8;
    localparam int AW   = 4;
    localparam int SS   = 2;
    localparam int HALF = 10;

    logic          clk = 1'b0;
    logic          rst, SCK, CS, PICO, CPOL, CPHA, POCI;
    logic [AW-1:0] host_addr, wr_addr;
    logic [BL-1:0] host_rdata, host_wdata, wr_data;
    logic          host_we, wr_strobe, frame_done, frame_err;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0, n_done = 0, n_err = 0, n_poci_hi = 0;
    logic [AW-1:0] last_wa = '0;
    logic [BL-1:0] last_wd = '0;

    spi_reg_responder #(.BUS_LENGTH(BL), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .PICO(PICO), .CPOL(CPOL), .CPHA(CPHA),
        .POCI(POCI), .host_addr(host_addr), .host_rdata(host_rdata), .host_we(host_we),
        .host_wdata(host_wdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            n_strobe++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (frame_done) n_done++;
        if (frame_err) n_err++;
        if (POCI) n_poci_hi++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [BL-1:0] d);
        @(negedge clk);
        host_addr = a;
        #1 d = host_rdata;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [BL-1:0] d);
        @(negedge clk);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // rst_at >= 0 pulses rst before that SCK cycle; collide raises host_we in the
    // exact cycle the final data sample (mode 0 leading edge) is acted upon.
    task automatic run_frame(input bit cpol, input bit cpha, input logic [7:0] cmd,
                             input logic [7:0] data, input int nclk, input int rst_at,
                             input bit collide, input logic [AW-1:0] c_addr,
                             input logic [BL-1:0] c_data, output logic [7:0] rd);
        logic [15:0] word;
        word = {cmd, data};
        rd   = '0;
        @(negedge clk);
        CPOL = cpol;
        CPHA = cpha;
        SCK  = cpol;
        repeat (20) @(negedge clk);
        CS = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq("rst_mid_POCI", POCI, 0);
                check_eq("rst_mid_strobe", wr_strobe, 0);
                check_eq("rst_mid_done", frame_done, 0);
                check_eq("rst_mid_err", frame_err, 0);
                check_eq("rst_mid_wr_addr", wr_addr, 0);
                check_eq("rst_mid_wr_data", wr_data, 0);
            end
            if (!cpha) begin
                PICO = word[15-i];
                repeat (HALF) @(negedge clk);
                if (i >= 8) rd = {rd[6:0], POCI};
                SCK = ~cpol;
                if (collide && i == 15) begin
                    repeat (SS) @(posedge clk);
                    @(negedge clk);
                    host_addr  = c_addr;
                    host_wdata = c_data;
                    host_we    = 1'b1;
                    @(negedge clk);
                    host_we = 1'b0;
                    repeat (HALF - 2) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                SCK = cpol;
            end else begin
                SCK  = ~cpol;
                PICO = word[15-i];
                repeat (HALF) @(negedge clk);
                if (i >= 8) rd = {rd[6:0], POCI};
                SCK = cpol;
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (HALF) @(negedge clk);
        CS = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd, v;
        int s0, d0, e0, p0;
        rst = 1'b1; SCK = 1'b0; CS = 1'b1; PICO = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
        host_addr = '0; host_wdata = '0; host_we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_POCI", POCI, 0);
        check_eq("reset_strobe", wr_strobe, 0);
        check_eq("reset_done", frame_done, 0);
        check_eq("reset_err", frame_err, 0);
        check_eq("reset_wr_addr", wr_addr, 0);
        check_eq("reset_wr_data", wr_data, 0);
        host_read(4'h3, v);
        check_eq("reset_reg3", v, 8'h00);

        // Mode 0 write 0xA5 to reg 3
        s0 = n_strobe; d0 = n_done; p0 = n_poci_hi;
        run_frame(1'b0, 1'b0, 8'h83, 8'hA5, 16, -1, 1'b0, '0, '0, rd);
        check_eq("m0_strobes", n_strobe - s0, 1);
        check_eq("m0_wr_addr", last_wa, 4'h3);
        check_eq("m0_wr_data", last_wd, 8'hA5);
        check_eq("m0_done", n_done - d0, 1);
        check_eq("m0_poci_quiet", n_poci_hi - p0, 0);
        host_read(4'h3, v);
        check_eq("m0_reg3", v, 8'hA5);

        // Mode 3 read of reg 3
        s0 = n_strobe; d0 = n_done;
        run_frame(1'b1, 1'b1, 8'h03, 8'h00, 16, -1, 1'b0, '0, '0, rd);
        check_eq("m3_read", rd, 8'hA5);
        check_eq("m3_strobes", n_strobe - s0, 0);
        check_eq("m3_done", n_done - d0, 1);

        // Mode 1 write 0x3C to reg 15, mode 2 read back
        run_frame(1'b0, 1'b1, 8'h8F, 8'h3C, 16, -1, 1'b0, '0, '0, rd);
        host_read(4'hF, v);
        check_eq("m1_reg15", v, 8'h3C);
        run_frame(1'b1, 1'b0, 8'h0F, 8'h00, 16, -1, 1'b0, '0, '0, rd);
        check_eq("m2_read", rd, 8'h3C);

        // Cmd 0xFF targets reg 15; read with ignored upper bits set
        run_frame(1'b0, 1'b0, 8'hFF, 8'hC3, 16, -1, 1'b0, '0, '0, rd);
        check_eq("ff_wr_addr", last_wa, 4'hF);
        host_read(4'hF, v);
        check_eq("ff_reg15", v, 8'hC3);
        run_frame(1'b0, 1'b1, 8'h7F, 8'h00, 16, -1, 1'b0, '0, '0, rd);
        check_eq("m1_read_7f", rd, 8'hC3);

        // Abort after 12 SCK cycles of a write to reg 2
        host_write(4'h2, 8'h5E);
        s0 = n_strobe; d0 = n_done; e0 = n_err;
        run_frame(1'b0, 1'b0, 8'h82, 8'h77, 12, -1, 1'b0, '0, '0, rd);
        check_eq("abort_err", n_err - e0, 1);
        check_eq("abort_strobes", n_strobe - s0, 0);
        check_eq("abort_done", n_done - d0, 0);
        host_read(4'h2, v);
        check_eq("abort_reg2", v, 8'h5E);
        s0 = n_strobe; e0 = n_err;
        run_frame(1'b0, 1'b0, 8'h82, 8'h77, 16, -1, 1'b0, '0, '0, rd);
        check_eq("after_abort_strobes", n_strobe - s0, 1);
        check_eq("after_abort_err", n_err - e0, 0);
        host_read(4'h2, v);
        check_eq("after_abort_reg2", v, 8'h77);

        // Same-address collision: SPI wins
        host_write(4'h5, 8'h00);
        run_frame(1'b0, 1'b0, 8'h85, 8'h22, 16, -1, 1'b1, 4'h5, 8'h11, rd);
        host_read(4'h5, v);
        check_eq("coll_same_reg5", v, 8'h22);
        // Different-address collision: both land
        host_write(4'h5, 8'h00);
        host_write(4'h6, 8'h00);
        run_frame(1'b0, 1'b0, 8'h85, 8'h22, 16, -1, 1'b1, 4'h6, 8'h11, rd);
        host_read(4'h6, v);
        check_eq("coll_diff_reg6", v, 8'h11);
        host_read(4'h5, v);
        check_eq("coll_diff_reg5", v, 8'h22);

        // Reset during DATA of a write to reg 4
        s0 = n_strobe; d0 = n_done; e0 = n_err;
        run_frame(1'b0, 1'b0, 8'h84, 8'h5A, 16, 11, 1'b0, '0, '0, rd);
        check_eq("rstmid_strobes", n_strobe - s0, 0);
        check_eq("rstmid_done", n_done - d0, 0);
        check_eq("rstmid_err", n_err - e0, 0);
        host_read(4'h4, v);
        check_eq("rstmid_reg4", v, 8'h00);
        host_read(4'h3, v);
        check_eq("rstmid_reg3_cleared", v, 8'h00);
        s0 = n_strobe;
        run_frame(1'b0, 1'b0, 8'h84, 8'h5A, 16, -1, 1'b0, '0, '0, rd);
        check_eq("post_rst_strobes", n_strobe - s0, 1);
        host_read(4'h4, v);
        check_eq("post_rst_reg4", v, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_responder.md
# spi_reg_responder

Register-mapped SPI responder: the far end of the team's SPI controller, oversampling the asynchronous SCK/CS/PICO lines on the local system clock. It decodes two-word command/data frames in any of the four CPOL/CPHA modes. Each frame either writes or reads a local register bank. Local logic reads the bank and can also write it.

## Interface
- BUS_LENGTH, 8: bits per SPI word (command word and data word); ≥ 4.
- ADDR_WIDTH, 4: register address width; bank holds 2**ADDR_WIDTH words; ADDR_WIDTH ≤ BUS_LENGTH-1.
- SYNC_STAGES, 2: synchronizer depth on SCK, CS, PICO; ≥ 2.

- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous and active-high.
- SCK, CS, PICO  in  1 each  SPI lines from the controller; asynchronous to clk.
- CPOL, CPHA  in  1 each  mode select; static while CS is low.
- POCI  out  1  serial read data, registered.
- host_addr  in  ADDR_WIDTH  local read/write address.
- host_rdata  out  BUS_LENGTH  combinational read of regs[host_addr].
- host_we, host_wdata  in  1 / BUS_LENGTH  local write, applied at the clk edge.
- wr_strobe  out  1  one-cycle pulse on each completed SPI write.
- wr_addr, wr_data  out  ADDR_WIDTH / BUS_LENGTH  valid while wr_strobe is high; hold their last value otherwise.
- frame_done  out  1  one-cycle pulse on each completed frame (read or write).
- frame_err  out  1  one-cycle pulse on an aborted frame.

## Operation
- Synchronizers: SCK, CS and PICO each pass through SYNC_STAGES flops. Reset loads the SCK synchronizer with CPOL, CS with 1, PICO with 0.
- Edge detection: compare synchronized SCK against its previous value.
  - Leading edge: SCK leaves CPOL. Trailing edge: SCK returns to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1.
  - Shift edge: the opposite edge.
- Frame format, MSB first:
  - Command word: bit [BUS_LENGTH-1] = 1 for write, 0 for read; address = bits [ADDR_WIDTH-1:0]; other bits ignored.
  - Data word: follows the command word.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE: on synchronized CS falling, go to CMD with bit_cnt=0.
  - CMD: shift synchronized PICO into rx on each sample edge. On the BUS_LENGTH-th sample: latch rw and addr, load tx ← regs[addr] (read) or 0 (write), go to DATA with bit_cnt=0.
  - DATA: shift PICO into rx on each sample edge. On the BUS_LENGTH-th sample:
    - if write, regs[addr] ← rx and pulse wr_strobe;
    - pulse frame_done; go to DONE.
  - DONE: ignore all SCK edges; wait for CS to go high.
- POCI:
  - Forced to 0 in IDLE and CMD.
  - In DATA, on each of the first BUS_LENGTH shift edges, POCI ← tx MSB, then tx shifts left.
  - After that, POCI = 0.
  - For CPHA=0, the first DATA shift edge is the trailing edge of command bit BUS_LENGTH-1.
- CS rising in any state returns the FSM to IDLE and sets POCI=0.
  - If the FSM is in CMD or DATA, pulse frame_err; the register bank is not modified.
- One frame per CS assertion; no bursts. CS must return high before the next frame.
- Host port:
  - host_we writes regs[host_addr].
  - On a same-cycle collision with an SPI write to the same address, the SPI write wins.
  - A collision on different addresses writes both.
- Reset values: all regs 0, POCI 0, wr_strobe 0, frame_done 0, frame_err 0, wr_addr 0, wr_data 0, state IDLE, bit counters 0.
- Reset asserted mid-frame aborts the frame silently: no frame_err, no write. The FSM stays in IDLE until the next CS falling edge after rst drops.

## Timing
- Pin edge to internal detection: SYNC_STAGES+1 clk cycles. Call the detection cycle N.
- Sample edge at cycle N: PICO is taken from the synchronizer output in cycle N.
- Final data sample at cycle N: at cycle N+1, wr_strobe, frame_done, wr_addr/wr_data and the updated regs value are all visible.
- Shift edge at cycle N: POCI changes at cycle N+1. Worst case from SCK pin to POCI pin: SYNC_STAGES+2 cycles.
- SCK high and low times must each be ≥ 2·(SYNC_STAGES+2) clk cycles (CLK_DIV ≥ 8 on the controller for defaults).
- CS must be high ≥ SYNC_STAGES+2 cycles between frames.
- CS setup to the first SCK edge must be ≥ SYNC_STAGES+2 cycles.
- CS rise at cycle N (detected): frame_err pulses at N+1.

## Test plan
- Mode 0 write: cmd 0x83, data 0xA5 → wr_strobe once with wr_addr=3, wr_data=0xA5; host_addr=3 reads 0xA5; POCI stays 0 throughout.
- Mode 3 read after that write: cmd 0x03 → POCI presents 1,0,1,0,0,1,0,1 on successive trailing (sample) edges; frame_done pulses; no wr_strobe.
- Modes 1 and 2: write 0x3C to address 0xF, then read it back → returns 0x3C. Cmd 0xFF with ADDR_WIDTH=4 addresses reg 15.
- Abort: CS rises after 12 SCK cycles of a write of 0x77 to address 2 → one frame_err pulse; regs[2] unchanged; the next full frame succeeds.
- Collision: host_we to addr 5 with 0x11 in the same cycle as an SPI write of 0x22 to addr 5 → regs[5]=0x22. The same test with host addr 6 → regs[6]=0x11 and regs[5]=0x22.
- Reset mid-frame: rst for 1 cycle during DATA → all outputs 0, no frame_err; with CS still low, the remaining SCK edges are ignored until CS cycles high and low again.
